ram_4x16_arbiter: RTL and testbench
===================================

# ram_4x16_arbiter

Two-port round-robin access controller for the 4x16 RAM. Two independent requesters issue single-word read or write transactions through a valid/ready handshake. The block serialises them onto the single RAM port (enable, write_enable, addr, dados_in, dados_out) and returns a one-cycle response per transaction. It sits between the requesting datapath blocks and the ram_4x16 instance, and is the only driver of the RAM control inputs.

## Interface
- ADDR_W, 2, RAM address width (4 words)
- DATA_W, 16, RAM word width
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid / req1_valid  input  1  requester has a transaction pending
- req0_we / req1_we  input  1  1 = write, 0 = read
- req0_addr / req1_addr  input  ADDR_W  word address
- req0_wdata / req1_wdata  input  DATA_W  write data
- req0_ready / req1_ready  output  1  transaction accepted on this edge when valid && ready
- rsp0_valid / rsp1_valid  output  1  one-cycle completion pulse
- rsp0_rdata / rsp1_rdata  output  DATA_W  read data; holds last read value until next read response on that port
- ram_enable  output  1  to RAM enable
- ram_write_enable  output  1  to RAM write_enable
- ram_addr  output  ADDR_W  to RAM addr
- ram_dados_in  output  DATA_W  to RAM dados_in
- ram_dados_out  input  DATA_W  from RAM dados_out (high-Z outside reads; never sampled then)
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WRITE, READ, CAPTURE.
- IDLE: RAM outputs inactive (enable=0, write_enable=0, addr=0, dados_in=0). Arbitration picks a winner. The winner's ready=1 and the loser's ready=0.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not served last wins.
  - Last-served pointer resets to 1, so req0 wins the first tie.
  - Pointer updates only on acceptance.
- Acceptance: valid && ready at an edge latches we, addr and wdata into internal registers. Goes to WRITE if we=1, else READ. Also records the owner.
- WRITE (1 cycle): enable=1, write_enable=1, addr/dados_in from latched registers. The RAM writes at the end of this cycle. Goes to IDLE.
- READ (1 cycle): enable=1, write_enable=0, addr latched. Goes to CAPTURE.
- CAPTURE (1 cycle): same RAM drive as READ. ram_dados_out is registered into the owner's rdata at the end of the cycle. Goes to IDLE. Two-cycle hold tolerates either combinational or registered RAM read.
- Response: the owner's rsp_valid pulses for exactly one cycle, the cycle after WRITE or CAPTURE (i.e. the first IDLE cycle).
  - Write response leaves rdata unchanged.
  - A new acceptance may occur in that same cycle.
- ready is a combinational function of state, both valids and the pointer. Requesters must not make valid depend on ready.
- ready is 0 in every non-IDLE state; pending valids wait.
- Async reset (any time, including mid-transaction):
  - State returns to IDLE and the pointer to 1.
  - All outputs go to 0: ready, rsp_valid, rdata, RAM signals, busy.
  - An in-flight transaction is dropped with no response. A write in its WRITE cycle may or may not complete.

## Timing
- Write: accept at edge T. WRITE during cycle T..T+1. rsp_valid high in cycle T+1..T+2. Throughput is 1 write per 2 cycles per block.
- Read: accept at edge T. READ in T..T+1, CAPTURE in T+1..T+2. rsp_valid and new rdata in T+2..T+3. Throughput is 1 read per 3 cycles.
- Back-to-back alternating requesters under continuous contention: grants strictly alternate 0,1,0,1.
- Address 3 to 0 needs no special handling: all 4 words are independent, with no wrap logic.

## Structure
- Package ram_ctrl_pkg holds:
  - ADDR_W and DATA_W defaults
  - state enum (IDLE, WRITE, READ, CAPTURE)
  - requester-id type (1 bit)
- Sub-module rr_arbiter_2: 2 valids + last-served pointer in, one-hot grant out, purely combinational. The pointer register lives in the top FSM.
- ram_4x16 is instantiated by the parent, not inside this block. The bench instantiates both.

## Test plan
- Reset then single write: req0 we=1 addr=2 wdata=16'hBEEF.
  - req0_ready=1 in IDLE.
  - ram_enable=ram_write_enable=1 and ram_addr=2 for exactly 1 cycle.
  - rsp0_valid pulses 2 cycles after accept.
  - rsp0_rdata stays 0.
- Read back: req1 we=0 addr=2 -> rsp1_valid 3 cycles after accept with rsp1_rdata=16'hBEEF. rsp0 stays silent.
- Contention: both valid continuously, reads of addr 0 and 1 (pre-written 16'h1111, 16'h2222).
  - First grant goes to req0, then alternation.
  - Each port gets its own data.
  - Neither ready is high while busy=1.
- Write-after-write same address: req0 writes 16'h0001, then req1 writes 16'hFFFF to addr 3. A subsequent read returns 16'hFFFF.
- Accept in response cycle: req1 valid held while req0's write completes -> req1 is accepted in the same cycle rsp0_valid=1, with no idle gap.
- Reset mid-read: assert rst_n=0 during CAPTURE.
  - All outputs go to 0 immediately.
  - No rsp pulse after release.
  - The next tie is granted to req0.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the 4x16 RAM access controller.
// Imported by the arbiter, the controller top and the RAM model.
package ram_ctrl_pkg;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE
    } state_t;

    typedef logic req_id_t;

    function automatic logic is_busy(state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/ram_4x16.sv
// 4-word by 16-bit RAM, synchronous write, registered read.
// dados_out updates only on read cycles and holds otherwise.
module ram_4x16
    import ram_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  enable,
    input  logic                  write_enable,
    input  logic [DEF_ADDR_W-1:0] addr,
    input  logic [DEF_DATA_W-1:0] dados_in,
    output logic [DEF_DATA_W-1:0] dados_out
);

    logic [DEF_DATA_W-1:0] mem [4];

    always_ff @(posedge clk) begin
        if (enable && write_enable) begin
            mem[addr] <= dados_in;
        end
        if (enable && !write_enable) begin
            dados_out <= mem[addr];
        end
    end

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant logic, purely combinational.
// The last-served pointer is owned by the caller.
module rr_arbiter_2
    import ram_ctrl_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (valid[0] && !valid[1]): grant = 2'b01;
            (valid[1] && !valid[0]): grant = 2'b10;
            (valid[0] &&  valid[1]): grant = last ? 2'b01 : 2'b10;
            default:                 grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_4x16_arbiter.sv
// Two-requester round-robin access controller for the 4x16 RAM.
// Serialises single-word reads/writes and returns one-cycle responses.
module ram_4x16_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              ram_enable,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dados_in,
    input  logic [DATA_W-1:0] ram_dados_out,
    output logic              busy
);

    state_t state_q;
    state_t state_d;

    req_id_t last_q;
    req_id_t owner_q;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0]        rsp_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic [1:0]        grant;
    logic              idle;
    logic              accept0;
    logic              accept1;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter_2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .last  (last_q),
        .grant (grant)
    );

    assign idle       = (state_q == IDLE);
    assign req0_ready = idle && grant[0];
    assign req1_ready = idle && grant[1];

    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;
    assign accept  = accept0 || accept1;

    assign sel_we    = accept1 ? req1_we    : req0_we;
    assign sel_addr  = accept1 ? req1_addr  : req0_addr;
    assign sel_wdata = accept1 ? req1_wdata : req0_wdata;

    assign busy       = is_busy(state_q);
    assign rsp0_valid = rsp_q[0];
    assign rsp1_valid = rsp_q[1];
    assign rsp0_rdata = rdata0_q;
    assign rsp1_rdata = rdata1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        ram_enable       = 1'b0;
        ram_write_enable = 1'b0;
        ram_addr         = '0;
        ram_dados_in     = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = sel_we ? WRITE : READ;
                end
            end
            WRITE: begin
                ram_enable       = 1'b1;
                ram_write_enable = we_q;
                ram_addr         = addr_q;
                ram_dados_in     = wdata_q;
                state_d          = IDLE;
            end
            READ: begin
                ram_enable = 1'b1;
                ram_addr   = addr_q;
                state_d    = CAPTURE;
            end
            CAPTURE: begin
                ram_enable = 1'b1;
                ram_addr   = addr_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transaction latch and round-robin pointer, updated only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else if (accept) begin
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            owner_q <= accept1;
            last_q  <= accept1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= 2'b00;
        end else begin
            rsp_q <= 2'b00;
            if (state_q == WRITE || state_q == CAPTURE) begin
                rsp_q[owner_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == CAPTURE) begin
            if (owner_q) begin
                rdata1_q <= ram_dados_out;
            end else begin
                rdata0_q <= ram_dados_out;
            end
        end
    end

endmodule

// File: tb/tb_ram_4x16_arbiter.sv
// Directed self-checking bench for ram_4x16_arbiter with a ram_4x16.
// Inputs change after edges; outputs are sampled around the falling edge.
module tb_ram_4x16_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_we = 1'b0;
    logic [1:0]  req0_addr = '0;
    logic [15:0] req0_wdata = '0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic        req1_we = 1'b0;
    logic [1:0]  req1_addr = '0;
    logic [15:0] req1_wdata = '0;
    logic        req1_ready;
    logic        rsp0_valid;
    logic [15:0] rsp0_rdata;
    logic        rsp1_valid;
    logic [15:0] rsp1_rdata;
    logic        ram_enable;
    logic        ram_write_enable;
    logic [1:0]  ram_addr;
    logic [15:0] ram_dados_in;
    logic [15:0] ram_dados_out;
    logic        busy;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_4x16_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req0_valid       (req0_valid),
        .req0_we          (req0_we),
        .req0_addr        (req0_addr),
        .req0_wdata       (req0_wdata),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_we          (req1_we),
        .req1_addr        (req1_addr),
        .req1_wdata       (req1_wdata),
        .req1_ready       (req1_ready),
        .rsp0_valid       (rsp0_valid),
        .rsp0_rdata       (rsp0_rdata),
        .rsp1_valid       (rsp1_valid),
        .rsp1_rdata       (rsp1_rdata),
        .ram_enable       (ram_enable),
        .ram_write_enable (ram_write_enable),
        .ram_addr         (ram_addr),
        .ram_dados_in     (ram_dados_in),
        .ram_dados_out    (ram_dados_out),
        .busy             (busy)
    );

    ram_4x16 u_ram (
        .clk          (clk),
        .enable       (ram_enable),
        .write_enable (ram_write_enable),
        .addr         (ram_addr),
        .dados_in     (ram_dados_in),
        .dados_out    (ram_dados_out)
    );

    // Drives one transaction on a port and waits for its response.
    task automatic do_txn(input int port, input logic we,
                          input logic [1:0] addr, input logic [15:0] data);
        bit acc;
        bit done;
        acc  = 1'b0;
        done = 1'b0;
        @(negedge clk);
        if (port == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = data;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = data;
        end
        for (int i = 0; i < 10 && !acc; i++) begin
            #1;
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) acc = 1'b1;
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int j = 0; j < 8 && !done; j++) begin
            @(negedge clk);
            #1;
            if ((port == 0 && rsp0_valid) || (port == 1 && rsp1_valid)) done = 1'b1;
        end
        n_assert++;
        if (!done) begin
            $display("FAIL txn_rsp port%0d: got no response, required one", port);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_assert++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b required 0", busy); n_fail++; end
        n_assert++; if (ram_enable !== 1'b0) begin $display("FAIL rst_en: got %b required 0", ram_enable); n_fail++; end
        n_assert++; if (ram_addr !== 2'd0) begin $display("FAIL rst_addr: got %h required 0", ram_addr); n_fail++; end
        n_assert++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin $display("FAIL rst_rsp: got %b%b required 00", rsp1_valid, rsp0_valid); n_fail++; end
        n_assert++; if (rsp0_rdata !== 16'h0 || rsp1_rdata !== 16'h0) begin $display("FAIL rst_rdata: got %h/%h required 0/0", rsp0_rdata, rsp1_rdata); n_fail++; end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 2'd2; req0_wdata = 16'hBEEF;
        #1;
        n_assert++; if (req0_ready !== 1'b1) begin $display("FAIL wr_ready: got %b required 1", req0_ready); n_fail++; end
        n_assert++; if (ram_enable !== 1'b0) begin $display("FAIL wr_idle_en: got %b required 0", ram_enable); n_fail++; end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        n_assert++; if (ram_enable !== 1'b1 || ram_write_enable !== 1'b1) begin $display("FAIL wr_en: got %b%b required 11", ram_enable, ram_write_enable); n_fail++; end
        n_assert++; if (ram_addr !== 2'd2) begin $display("FAIL wr_addr: got %h required 2", ram_addr); n_fail++; end
        n_assert++; if (ram_dados_in !== 16'hBEEF) begin $display("FAIL wr_data: got %h required beef", ram_dados_in); n_fail++; end
        n_assert++; if (busy !== 1'b1 || req0_ready !== 1'b0) begin $display("FAIL wr_busy: got busy=%b ready=%b required 1/0", busy, req0_ready); n_fail++; end
        n_assert++; if (rsp0_valid !== 1'b0) begin $display("FAIL wr_rsp_early: got %b required 0", rsp0_valid); n_fail++; end
        @(negedge clk);
        n_assert++; if (rsp0_valid !== 1'b1) begin $display("FAIL wr_rsp: got %b required 1", rsp0_valid); n_fail++; end
        n_assert++; if (ram_enable !== 1'b0 || ram_write_enable !== 1'b0) begin $display("FAIL wr_en_off: got %b%b required 00", ram_enable, ram_write_enable); n_fail++; end
        n_assert++; if (rsp0_rdata !== 16'h0) begin $display("FAIL wr_rdata: got %h required 0", rsp0_rdata); n_fail++; end
        @(negedge clk);
        n_assert++; if (rsp0_valid !== 1'b0) begin $display("FAIL wr_rsp_pulse: got %b required 0", rsp0_valid); n_fail++; end
    endtask

    task automatic test_read_back();
        @(negedge clk);
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 2'd2;
        #1;
        n_assert++; if (req1_ready !== 1'b1) begin $display("FAIL rd_ready: got %b required 1", req1_ready); n_fail++; end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        n_assert++; if (ram_enable !== 1'b1 || ram_write_enable !== 1'b0 || ram_addr !== 2'd2) begin $display("FAIL rd_drive: got en=%b we=%b a=%h required 1/0/2", ram_enable, ram_write_enable, ram_addr); n_fail++; end
        @(negedge clk);
        n_assert++; if (rsp1_valid !== 1'b0 || ram_enable !== 1'b1) begin $display("FAIL rd_capture: got rsp=%b en=%b required 0/1", rsp1_valid, ram_enable); n_fail++; end
        @(negedge clk);
        n_assert++; if (rsp1_valid !== 1'b1) begin $display("FAIL rd_rsp: got %b required 1", rsp1_valid); n_fail++; end
        n_assert++; if (rsp1_rdata !== 16'hBEEF) begin $display("FAIL rd_data: got %h required beef", rsp1_rdata); n_fail++; end
        n_assert++; if (rsp0_valid !== 1'b0 || rsp0_rdata !== 16'h0) begin $display("FAIL rd_port0_quiet: got %b/%h required 0/0", rsp0_valid, rsp0_rdata); n_fail++; end
        @(negedge clk);
        n_assert++; if (rsp1_valid !== 1'b0 || rsp1_rdata !== 16'hBEEF) begin $display("FAIL rd_hold: got %b/%h required 0/beef", rsp1_valid, rsp1_rdata); n_fail++; end
    endtask

    task automatic test_contention();
        int  g[$];
        int  r0;
        int  r1;
        bit  overlap;
        r0 = 0;
        r1 = 0;
        overlap = 1'b0;
        do_txn(0, 1'b1, 2'd0, 16'h1111);
        do_txn(1, 1'b1, 2'd1, 16'h2222);
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 2'd0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 2'd1;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (busy && (req0_ready || req1_ready)) overlap = 1'b1;
            if (req0_valid && req0_ready) g.push_back(0);
            if (req1_valid && req1_ready) g.push_back(1);
            if (rsp0_valid) begin
                r0++;
                n_assert++; if (rsp0_rdata !== 16'h1111) begin $display("FAIL cont_data0: got %h required 1111", rsp0_rdata); n_fail++; end
            end
            if (rsp1_valid) begin
                r1++;
                n_assert++; if (rsp1_rdata !== 16'h2222) begin $display("FAIL cont_data1: got %h required 2222", rsp1_rdata); n_fail++; end
            end
            @(posedge clk); #1;
            if (g.size() >= 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_assert++; if (g.size() != 4) begin $display("FAIL cont_grants: got %0d grants required 4", g.size()); n_fail++; end
        for (int k = 0; k < g.size() && k < 4; k++) begin
            n_assert++; if (g[k] != (k % 2)) begin $display("FAIL cont_order[%0d]: got req%0d required req%0d", k, g[k], k % 2); n_fail++; end
        end
        n_assert++; if (r0 != 2 || r1 != 2) begin $display("FAIL cont_rsp_count: got %0d/%0d required 2/2", r0, r1); n_fail++; end
        n_assert++; if (overlap) begin $display("FAIL cont_ready_busy: got ready while busy, required none"); n_fail++; end
    endtask

    task automatic test_waw();
        do_txn(0, 1'b1, 2'd3, 16'h0001);
        do_txn(1, 1'b1, 2'd3, 16'hFFFF);
        do_txn(0, 1'b0, 2'd3, 16'h0000);
        n_assert++; if (rsp0_rdata !== 16'hFFFF) begin $display("FAIL waw_data: got %h required ffff", rsp0_rdata); n_fail++; end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 2'd1; req0_wdata = 16'h3333;
        #1;
        n_assert++; if (req0_ready !== 1'b1) begin $display("FAIL b2b_ready0: got %b required 1", req0_ready); n_fail++; end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 2'd2;
        #1;
        n_assert++; if (req1_ready !== 1'b0 || busy !== 1'b1) begin $display("FAIL b2b_wait: got ready=%b busy=%b required 0/1", req1_ready, busy); n_fail++; end
        @(negedge clk);
        #1;
        n_assert++; if (rsp0_valid !== 1'b1 || req1_ready !== 1'b1) begin $display("FAIL b2b_overlap: got rsp0=%b ready1=%b required 1/1", rsp0_valid, req1_ready); n_fail++; end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        n_assert++; if (busy !== 1'b1 || ram_enable !== 1'b1 || ram_write_enable !== 1'b0 || ram_addr !== 2'd2) begin $display("FAIL b2b_read: got busy=%b en=%b we=%b a=%h required 1/1/0/2", busy, ram_enable, ram_write_enable, ram_addr); n_fail++; end
        @(negedge clk);
        @(negedge clk);
        n_assert++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 16'hBEEF) begin $display("FAIL b2b_rsp1: got %b/%h required 1/beef", rsp1_valid, rsp1_rdata); n_fail++; end
    endtask

    task automatic test_reset_mid_read();
        int stray;
        stray = 0;
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 2'd3;
        #1;
        n_assert++; if (req0_ready !== 1'b1) begin $display("FAIL mr_ready: got %b required 1", req0_ready); n_fail++; end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_assert++; if (busy !== 1'b1 || ram_enable !== 1'b1) begin $display("FAIL mr_capture: got busy=%b en=%b required 1/1", busy, ram_enable); n_fail++; end
        #1;
        rst_n = 1'b0;
        #1;
        n_assert++; if (busy !== 1'b0 || ram_enable !== 1'b0 || ram_addr !== 2'd0) begin $display("FAIL mr_ram: got busy=%b en=%b a=%h required 0/0/0", busy, ram_enable, ram_addr); n_fail++; end
        n_assert++; if (rsp0_rdata !== 16'h0 || rsp1_rdata !== 16'h0) begin $display("FAIL mr_rdata: got %h/%h required 0/0", rsp0_rdata, rsp1_rdata); n_fail++; end
        n_assert++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin $display("FAIL mr_rsp: got %b%b required 00", rsp1_valid, rsp0_valid); n_fail++; end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (rsp0_valid || rsp1_valid) stray++;
        end
        n_assert++; if (stray != 0) begin $display("FAIL mr_no_rsp: got %0d pulses required 0", stray); n_fail++; end
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 2'd0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 2'd1;
        #1;
        n_assert++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin $display("FAIL mr_tie: got ready=%b%b required 01", req1_ready, req0_ready); n_fail++; end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_back();
        test_contention();
        test_waw();
        test_back_to_back();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
